// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, edge-strobe bundle and
// the helper that picks the sampling SCLK edge for a given mode.
package spi_pkg;

    localparam bit CPOL_IDLE_LOW  = 1'b0;
    localparam bit CPOL_IDLE_HIGH = 1'b1;
    localparam bit CPHA_LEAD      = 1'b0;
    localparam bit CPHA_TRAIL     = 1'b1;

    localparam int MIN_OVERSAMPLE = 8;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_t;

    // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Word-level handshake bundle between the SPI slave and on-chip logic.
interface spi_slave_sync_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rx_overrun;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic                  busy;

    modport slave (
        output rx_data, rx_valid, rx_overrun,
        output tx_ready, tx_underrun, busy,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, rx_overrun,
        input  tx_ready, tx_underrun, busy,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one-cycle rise/fall strobes on the synced level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  d_i,
    output edge_t sig_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              lvl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl   = sync_q[STAGES-1];
    assign sig_o = '{level: lvl, rise: lvl & ~prev_q, fall: ~lvl & prev_q};

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampled SPI slave: pins are synchronised to CLK, words are exchanged
// through valid/ready handshakes with overrun/underrun pulses.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SCLK,
    input  logic            SS,
    input  logic            MOSI,
    output wire             MISO,
    output logic            MISO_OE,
    spi_slave_sync_if.slave bus
);

    localparam int                CW     = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST   = CW'(DATA_WIDTH - 1);
    localparam logic              S_RISE = sample_on_rise(CPOL, CPHA);

    edge_t sclk_e;
    edge_t ss_e;

    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    logic                  armed_q;
    logic                  active;
    logic                  ss_start;
    logic                  ss_stop;
    logic                  sample_stb;
    logic                  shift_stb;
    logic                  word_end;
    logic                  word_start;

    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_ovr_q, rx_ovr_d;
    logic                  accept;

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  load;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  first_q, first_d;
    logic                  miso_q, miso_d;
    logic                  tx_undr_q, tx_undr_d;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (SCLK),
        .sig_o (sclk_e)
    );

    // SS resets low-synced and needs a seen-high before arming, so a frame
    // interrupted by RST resumes only after a real SS falling edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (SS),
        .sig_o (ss_e)
    );

    assign mosi_s     = mosi_q[SYNC_STAGES-1];
    assign active     = armed_q & ~ss_e.level;
    assign ss_start   = armed_q & ss_e.fall;
    assign ss_stop    = ss_e.rise;
    assign sample_stb = active & (S_RISE ? sclk_e.rise : sclk_e.fall);
    assign shift_stb  = active & (S_RISE ? sclk_e.fall : sclk_e.rise);
    assign word_end   = sample_stb & (bit_cnt_q == LAST);
    assign word_start = ss_start | word_end;

    assign accept     = done_q & (~rx_valid_q | bus.rx_ready);
    assign rx_data_d  = accept ? rx_shift_q : rx_data_q;
    assign rx_valid_d = accept | (rx_valid_q & ~bus.rx_ready);
    assign rx_ovr_d   = done_q & rx_valid_q & ~bus.rx_ready;

    assign load        = bus.tx_valid & ~hold_full_q;
    assign hold_d      = load ? bus.tx_data : hold_q;
    assign hold_full_d = load | (hold_full_q & ~word_start);
    assign tx_undr_d   = word_start & ~hold_full_q;

    always_comb begin
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        first_d    = first_q;
        miso_d     = miso_q;
        if (ss_stop) begin
            rx_shift_d = '0;
            bit_cnt_d  = '0;
            tx_shift_d = '0;
            first_d    = 1'b0;
        end else begin
            if (sample_stb) begin
                rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                bit_cnt_d  = word_end ? '0 : bit_cnt_q + CW'(1);
            end
            // A back-to-back load in CPHA=0 must skip the trailing edge of the old word.
            if (word_start) begin
                tx_shift_d = hold_full_q ? hold_q : '0;
                first_d    = CPHA || word_end;
            end else if (shift_stb) begin
                if (first_q) first_d = 1'b0;
                else tx_shift_d = tx_shift_q << 1;
            end
            if (CPHA == CPHA_LEAD) miso_d = tx_shift_d[DATA_WIDTH-1];
            else if (shift_stb) miso_d = tx_shift_d[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mosi_q      <= '0;
            armed_q     <= 1'b0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            done_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            first_q     <= 1'b0;
            miso_q      <= 1'b0;
            tx_undr_q   <= 1'b0;
        end else begin
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            armed_q     <= armed_q | ss_e.level;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            done_q      <= word_end;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            first_q     <= first_d;
            miso_q      <= miso_d;
            tx_undr_q   <= tx_undr_d;
        end
    end

    assign MISO_OE         = active;
    assign MISO            = MISO_OE ? miso_q : 1'bz;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_overrun  = rx_ovr_q;
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.tx_underrun = tx_undr_q;
    assign bus.busy        = active;

endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Next-generation SPI slave, fully synchronous to the system clock. SCLK, SS and MOSI are oversampled, not used as clocks.
- Parametrised word width and SPI mode (CPOL/CPHA).
- Valid/ready handshakes on both the receive and transmit sides, plus overrun/underrun flags.
- Sits between the external SPI pins and the on-chip register/control logic, replacing direct SCLK-clocked capture.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (range 4..32); MSB first.
- CPOL, 0, SCLK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2, synchroniser flops on SCLK, SS and MOSI (minimum 2).

Ports:
- CLK  in  1  system clock; must be at least 8x SCLK.
- RST  in  1  asynchronous, active-high reset.
- SCLK  in  1  SPI clock from master.
- SS  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data; 1'bz whenever MISO_OE = 0.
- MISO_OE  out  1  high while the synchronised SS is low.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out  1  one-cycle pulse: a word completed while rx_valid = 1.
- tx_data  in  DATA_WIDTH  next word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  tx holding register is empty.
- tx_underrun  out  1  one-cycle pulse: a word started with the holding register empty.
- busy  out  1  frame in progress (synchronised SS low).

Behaviour:
- Reset values: rx_data = 0, rx_valid = 0, rx_overrun = 0, tx_ready = 1, tx_underrun = 0, MISO_OE = 0, busy = 0. All shift registers and the bit counter are cleared.
- Synchronisation: SCLK, SS and MOSI each pass through SYNC_STAGES flops. Edge detect on the synced SCLK/SS gives one-cycle strobes.
- Leading edge = rising if CPOL = 0, else falling.
- sample_stb = leading edge if CPHA = 0, trailing edge if CPHA = 1. shift_stb = the opposite edge.
- Word start occurs on the SS falling strobe, or on the sample_stb that completes a word while SS stays low (back-to-back words). At word start:
  - If the holding register is full, its contents go to tx_shift and tx_ready returns to 1.
  - If it is empty, tx_shift = 0 and tx_underrun pulses.
- MISO is driven from a register equal to tx_shift[DATA_WIDTH-1].
  - CPHA = 0: the MSB is valid from word start. Each shift_stb moves tx_shift left by 1.
  - CPHA = 1: the first leading-edge shift_stb presents the MSB, with no shift. Each later shift_stb shifts.
- On each sample_stb: rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_sync}, and bit_cnt increments.
- When bit_cnt reaches DATA_WIDTH-1 on a sample_stb:
  - Next cycle, if rx_valid = 0: rx_data <= completed word, rx_valid = 1.
  - If rx_valid = 1: the new word is dropped, the old rx_data is kept, and rx_overrun pulses.
  - bit_cnt wraps to 0.
- Latency: rx_valid rises SYNC_STAGES+2 CLK cycles after the final sampling SCLK edge at the pin.
- rx_valid clears in the cycle after rx_valid && rx_ready. A simultaneous clear and new-word completion loads the new word, keeps rx_valid = 1, and gives no overrun.
- tx handshake: tx_valid && tx_ready loads the holding register; tx_ready drops next cycle. A simultaneous load and word-start consumption of an empty register: the new word waits for the next word (underrun still pulses).
- SS rising mid-word:
  - The partial rx word is discarded and bit_cnt = 0. No rx_valid, no overrun.
  - The tx word already loaded into tx_shift is lost.
  - The holding register is unaffected. MISO_OE drops.
- Glitches: SCLK edges while SS is high are ignored.
- RST asserted mid-frame: immediate return to reset values; the frame is resumed only at the next SS falling edge.

Decomposition:
- Shared package spi_pkg: CPOL/CPHA mode constants, MIN_OVERSAMPLE = 8, and a function deriving the sample-edge polarity from (CPOL, CPHA).
- Sub-module spi_sync_edge (SYNC_STAGES flops + rise/fall strobes), instantiated for SCLK and SS. MOSI uses the synchroniser only.

Test Plan:
- Mode 0, DATA_WIDTH = 8, CLK = 16x SCLK. tx_data = 0xA5 preloaded; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data = 0x3C; rx_valid rises 4 CLK after the 8th rising SCLK.
- Modes 1, 2, 3 each: send 0x96 and return 0x69 -> correct sampling edge; master reads 0x69; slave receives 0x96.
- Two back-to-back words 0x11, 0x22 with SS held low, rx_ready tied 0 -> rx_data = 0x11 and one rx_overrun pulse; after rx_ready, the word 0x22 is never presented.
- SS falls with tx holding register empty -> tx_underrun pulse; MISO = 0 for all 8 bits; tx_ready stays 1.
- SS deasserted after 5 bits of 0xFF -> no rx_valid; MISO = z; the next full frame 0x81 gives rx_data = 0x81.
- DATA_WIDTH = 16, mode 0, 0xBEEF both directions; RST pulsed mid-frame -> all outputs return to reset values asynchronously; the next frame completes correctly.
